// File: rtl/dcb_cdc_pkg.sv
// Shared types and helpers for the dcb_clk-side launch arbiter of the
// dcb_clk -> sys_clk pulse-synchroniser channel.
package dcb_cdc_pkg;

   // Launch sequencer states: wait for a request, hold the strobe, then enforce spacing.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GUARD = 2'd2
   } dcb_state_e;

   // Width of the shared PULSE/GUARD down-counter so it can hold any value up to gap_cycles.
   function automatic int cnt_width(input int gap_cycles);
      return $clog2(gap_cycles + 1);
   endfunction

endpackage

// File: rtl/dcb_rr_pick.sv
// Combinational rotate-priority picker: the first set request bit found
// scanning upward from rr_ptr+1, wrapping modulo NUM_REQ, wins.
module dcb_rr_pick #(
   parameter  int NUM_REQ  = 4,
   localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] idx,
   output logic                any_valid
);

   // Scan every requester once starting just after the last winner; the first hit wins.
   always_comb begin
      int   slot;
      logic found;
      slot  = 0;
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         slot = (int'(rr_ptr) + off) % NUM_REQ;
         if (!found && req[slot]) begin
            found       = 1'b1;
            grant[slot] = 1'b1;
            idx         = ID_WIDTH'(slot);
         end
      end
      any_valid = found;
   end

endmodule

// File: rtl/dcb_cdc_launch_arb.sv
// Round-robin arbiter and launch sequencer sharing one dcb_clk -> sys_clk
// pulse-synchroniser channel between NUM_REQ requesters. Each launch holds
// dcb_out_val for PULSE_CYCLES cycles and successive launches rise at least
// GAP_CYCLES cycles apart so the sys_clk side detects every pulse.
module dcb_cdc_launch_arb
   import dcb_cdc_pkg::*;
#(
   parameter  int NUM_REQ      = 4,
   parameter  int DATA_WIDTH   = 32,
   parameter  int PULSE_CYCLES = 1,
   parameter  int GAP_CYCLES   = 8,
   localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
   input  logic                          dcb_clk,
   input  logic                          dcb_rst,
   input  logic                          dcb_en,
   input  logic [NUM_REQ-1:0]            dcb_in_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] dcb_in_data,
   output logic [NUM_REQ-1:0]            dcb_in_ack,
   output logic                          dcb_out_val,
   output logic [DATA_WIDTH-1:0]         dcb_out_data,
   output logic [ID_WIDTH-1:0]           dcb_out_id,
   output logic                          dcb_busy
);

   localparam int CNT_WIDTH = cnt_width(GAP_CYCLES);
   localparam logic [CNT_WIDTH-1:0] PULSE_LOAD = CNT_WIDTH'(PULSE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GUARD_LOAD = CNT_WIDTH'(GAP_CYCLES - PULSE_CYCLES - 2);
   localparam logic [ID_WIDTH-1:0]  PTR_RESET  = ID_WIDTH'(NUM_REQ - 1);

   dcb_state_e             state_q;
   dcb_state_e             state_d;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [ID_WIDTH-1:0]    rr_ptr_q;
   logic [NUM_REQ-1:0]     ack_q;
   logic [DATA_WIDTH-1:0]  data_q;
   logic [ID_WIDTH-1:0]    id_q;

   logic [NUM_REQ-1:0]     pick_grant;
   logic [ID_WIDTH-1:0]    pick_idx;
   logic                   pick_any;
   logic                   launch;
   logic                   cnt_zero;

   dcb_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req       (dcb_in_req),
      .rr_ptr    (rr_ptr_q),
      .grant     (pick_grant),
      .idx       (pick_idx),
      .any_valid (pick_any)
   );

   assign launch   = (state_q == IDLE) && dcb_en && pick_any;
   assign cnt_zero = (cnt_q == '0);

   // State register; reset abandons any sequence in flight.
   always_ff @(posedge dcb_clk) begin
      if (dcb_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: arbitrate only in IDLE, leave PULSE/GUARD when the counter runs out.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (launch)   state_d = PULSE;
         PULSE:   if (cnt_zero) state_d = GUARD;
         GUARD:   if (cnt_zero) state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // One down-counter times both the strobe width and the guard gap, stopping at zero.
   always_ff @(posedge dcb_clk) begin
      if (dcb_rst) begin
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE:    if (launch) cnt_q <= PULSE_LOAD;
            PULSE:   cnt_q <= cnt_zero ? GUARD_LOAD : cnt_q - CNT_WIDTH'(1);
            GUARD:   if (!cnt_zero) cnt_q <= cnt_q - CNT_WIDTH'(1);
            default: cnt_q <= '0;
         endcase
      end
   end

   // Capture the winner at the arbitration edge; the ack lasts exactly one cycle.
   always_ff @(posedge dcb_clk) begin
      if (dcb_rst) begin
         ack_q    <= '0;
         data_q   <= '0;
         id_q     <= '0;
         rr_ptr_q <= PTR_RESET;
      end else begin
         ack_q <= '0;
         if (launch) begin
            ack_q    <= pick_grant;
            data_q   <= dcb_in_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            id_q     <= pick_idx;
            rr_ptr_q <= pick_idx;
         end
      end
   end

   // Strobe and busy come straight from the registered state.
   always_comb begin
      dcb_out_val = 1'b0;
      dcb_busy    = 1'b0;
      case (state_q)
         PULSE: begin
            dcb_out_val = 1'b1;
            dcb_busy    = 1'b1;
         end
         GUARD:   dcb_busy = 1'b1;
         default: ;
      endcase
   end

   assign dcb_in_ack   = ack_q;
   assign dcb_out_data = data_q;
   assign dcb_out_id   = id_q;

endmodule

// File: tb/tb_dcb_cdc_launch_arb.sv
// Directed self-checking bench for dcb_cdc_launch_arb. Two instances share
// the stimulus: dut1 with PULSE_CYCLES=1 and dut3 with PULSE_CYCLES=3.
// Cycle n is the cycle that follows clock edge n-1; outputs are sampled
// on the falling edge and inputs are driven there too.
module tb_dcb_cdc_launch_arb;

   logic         dcb_clk;
   logic         dcb_rst;
   logic         dcb_en;
   logic [3:0]   dcb_in_req;
   logic [127:0] dcb_in_data;

   logic [3:0]   ack1, ack3;
   logic         val1, val3;
   logic [31:0]  data1, data3;
   logic [1:0]   id1, id3;
   logic         busy1, busy3;

   int tests_run;
   int tests_failed;

   dcb_cdc_launch_arb #(
      .NUM_REQ      (4),
      .DATA_WIDTH   (32),
      .PULSE_CYCLES (1),
      .GAP_CYCLES   (8)
   ) dut1 (
      .dcb_clk      (dcb_clk),
      .dcb_rst      (dcb_rst),
      .dcb_en       (dcb_en),
      .dcb_in_req   (dcb_in_req),
      .dcb_in_data  (dcb_in_data),
      .dcb_in_ack   (ack1),
      .dcb_out_val  (val1),
      .dcb_out_data (data1),
      .dcb_out_id   (id1),
      .dcb_busy     (busy1)
   );

   dcb_cdc_launch_arb #(
      .NUM_REQ      (4),
      .DATA_WIDTH   (32),
      .PULSE_CYCLES (3),
      .GAP_CYCLES   (8)
   ) dut3 (
      .dcb_clk      (dcb_clk),
      .dcb_rst      (dcb_rst),
      .dcb_en       (dcb_en),
      .dcb_in_req   (dcb_in_req),
      .dcb_in_data  (dcb_in_data),
      .dcb_in_ack   (ack3),
      .dcb_out_val  (val3),
      .dcb_out_data (data3),
      .dcb_out_id   (id3),
      .dcb_busy     (busy3)
   );

   // Free-running 10 ns clock.
   initial dcb_clk = 1'b0;
   always #5 dcb_clk = ~dcb_clk;

   // Advance through one active edge and land on the following falling edge.
   task automatic tick();
      @(posedge dcb_clk);
      @(negedge dcb_clk);
   endtask

   // Hold reset for two edges with all inputs quiet.
   task automatic do_reset();
      dcb_rst     = 1'b1;
      dcb_en      = 1'b0;
      dcb_in_req  = 4'b0000;
      dcb_in_data = '0;
      tick();
      tick();
      dcb_rst = 1'b0;
   endtask

   // Reset values on both instances, then IDLE holds with no request.
   task automatic test_reset();
      do_reset();
      tests_run++;
      if ({val1, ack1, data1, id1, busy1} !== {1'b0, 4'b0000, 32'h0, 2'd0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_dut1: got %h expected %h", {val1, ack1, data1, id1, busy1}, 40'h0);
      end
      tests_run++;
      if ({val3, ack3, data3, id3, busy3} !== {1'b0, 4'b0000, 32'h0, 2'd0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_dut3: got %h expected %h", {val3, ack3, data3, id3, busy3}, 40'h0);
      end
      dcb_en = 1'b1;
      tick();
      tests_run++;
      if ({val1, busy1, ack1} !== 6'b0) begin
         tests_failed++;
         $display("[TB] FAIL idle_no_req: got %b expected %b", {val1, busy1, ack1}, 6'b0);
      end
   endtask

   // One requester: strobe at cycle 1, busy through cycle 7, IDLE at cycle 8 with data held.
   task automatic test_single();
      do_reset();
      dcb_in_data[2*32 +: 32] = 32'hA5A5_0002;
      dcb_in_req = 4'b0100;
      dcb_en     = 1'b1;
      tick();
      tests_run++;
      if ({val1, ack1, id1, data1, busy1} !== {1'b1, 4'b0100, 2'd2, 32'hA5A5_0002, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL single_c1: got %h expected %h",
                  {val1, ack1, id1, data1, busy1}, {1'b1, 4'b0100, 2'd2, 32'hA5A5_0002, 1'b1});
      end
      dcb_in_req = 4'b0000;
      for (int c = 2; c <= 7; c++) begin
         tick();
         tests_run++;
         if ({val1, ack1, busy1} !== {1'b0, 4'b0000, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL single_guard_c%0d: got %b expected %b", c, {val1, ack1, busy1}, 6'b000001);
         end
      end
      tick();
      tests_run++;
      if ({busy1, val1, data1} !== {1'b0, 1'b0, 32'hA5A5_0002}) begin
         tests_failed++;
         $display("[TB] FAIL single_c8: got %h expected %h", {busy1, val1, data1}, {2'b00, 32'hA5A5_0002});
      end
   endtask

   // All four held: grants 0,1,2,3,0 rising every 8 cycles with a single ack bit each.
   task automatic test_round_robin();
      logic        exp_val;
      logic [1:0]  exp_id;
      logic [3:0]  exp_ack;
      logic [31:0] exp_data;
      do_reset();
      for (int i = 0; i < 4; i++) dcb_in_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      dcb_in_req = 4'b1111;
      dcb_en     = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         tick();
         exp_val  = ((c - 1) % 8 == 0);
         exp_id   = 2'(((c - 1) / 8) % 4);
         exp_ack  = exp_val ? (4'b0001 << exp_id) : 4'b0000;
         exp_data = 32'h1000_0000 + 32'(exp_id);
         tests_run++;
         if ({val1, ack1} !== {exp_val, exp_ack}) begin
            tests_failed++;
            $display("[TB] FAIL rr_c%0d: got val/ack %b expected %b", c, {val1, ack1}, {exp_val, exp_ack});
         end
         if (exp_val) begin
            tests_run++;
            if ({id1, data1} !== {exp_id, exp_data}) begin
               tests_failed++;
               $display("[TB] FAIL rr_grant_c%0d: got id/data %h expected %h", c, {id1, data1}, {exp_id, exp_data});
            end
         end
      end
   endtask

   // Three-cycle strobe: data frozen despite payload change after ack; next rise at cycle 9.
   task automatic test_pulse3();
      logic        exp_val;
      logic        exp_busy;
      logic [3:0]  exp_ack;
      logic [31:0] exp_data;
      do_reset();
      dcb_in_data[2*32 +: 32] = 32'hC0DE_0003;
      dcb_in_req = 4'b0100;
      dcb_en     = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1) dcb_in_data[2*32 +: 32] = 32'hFFFF_FFFF;
         exp_val  = (c <= 3) || (c == 9);
         exp_busy = (c <= 7) || (c == 9);
         exp_ack  = ((c == 1) || (c == 9)) ? 4'b0100 : 4'b0000;
         exp_data = (c == 9) ? 32'hFFFF_FFFF : 32'hC0DE_0003;
         tests_run++;
         if ({val3, busy3, ack3, data3} !== {exp_val, exp_busy, exp_ack, exp_data}) begin
            tests_failed++;
            $display("[TB] FAIL pulse3_c%0d: got %h expected %h", c,
                     {val3, busy3, ack3, data3}, {exp_val, exp_busy, exp_ack, exp_data});
         end
      end
   endtask

   // Enable low blocks arbitration; raising it launches next cycle; lowering mid-sequence completes it.
   task automatic test_enable();
      do_reset();
      dcb_in_data[1*32 +: 32] = 32'hBEEF_0001;
      dcb_in_req = 4'b0010;
      dcb_en     = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         tests_run++;
         if ({val1, ack1, busy1} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL en_low_c%0d: got %b expected %b", c, {val1, ack1, busy1}, 6'b0);
         end
      end
      dcb_en = 1'b1;
      tick();
      tests_run++;
      if ({val1, ack1, id1, data1} !== {1'b1, 4'b0010, 2'd1, 32'hBEEF_0001}) begin
         tests_failed++;
         $display("[TB] FAIL en_launch_c21: got %h expected %h",
                  {val1, ack1, id1, data1}, {1'b1, 4'b0010, 2'd1, 32'hBEEF_0001});
      end
      dcb_en = 1'b0;
      for (int c = 22; c <= 29; c++) begin
         tick();
         tests_run++;
         if ({val1, ack1, busy1} !== {1'b0, 4'b0000, (c <= 27)}) begin
            tests_failed++;
            $display("[TB] FAIL en_drop_c%0d: got %b expected %b", c, {val1, ack1, busy1}, {5'b0, (c <= 27)});
         end
      end
   endtask

   // Reset during a three-cycle strobe: stops at once, no re-ack, pointer back to favour requester 0.
   task automatic test_reset_mid();
      do_reset();
      dcb_in_data[0*32 +: 32] = 32'h0000_AAAA;
      dcb_in_data[3*32 +: 32] = 32'h3333_3333;
      dcb_in_req = 4'b1001;
      dcb_en     = 1'b1;
      tick();
      tests_run++;
      if ({val3, ack3, id3} !== {1'b1, 4'b0001, 2'd0}) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_c1: got %b expected %b", {val3, ack3, id3}, 7'b1000100);
      end
      tick();
      tests_run++;
      if ({val3, ack3} !== {1'b1, 4'b0000}) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_c2: got %b expected %b", {val3, ack3}, 5'b10000);
      end
      dcb_rst = 1'b1;
      tick();
      tests_run++;
      if ({val3, busy3, ack3, data3, id3} !== {1'b0, 1'b0, 4'b0000, 32'h0, 2'd0}) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_c3: got %h expected %h", {val3, busy3, ack3, data3, id3}, 40'h0);
      end
      dcb_rst = 1'b0;
      tick();
      tests_run++;
      if ({val3, ack3, id3, data3} !== {1'b1, 4'b0001, 2'd0, 32'h0000_AAAA}) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_c4: got %h expected %h",
                  {val3, ack3, id3, data3}, {1'b1, 4'b0001, 2'd0, 32'h0000_AAAA});
      end
   endtask

   // Requester 1 withdraws during GUARD, so the next grant after 0 skips to 3.
   task automatic test_withdraw();
      do_reset();
      dcb_in_data[0*32 +: 32] = 32'h0000_0000;
      dcb_in_data[1*32 +: 32] = 32'h1111_1111;
      dcb_in_data[3*32 +: 32] = 32'h3333_3333;
      dcb_in_req = 4'b1011;
      dcb_en     = 1'b1;
      tick();
      tests_run++;
      if ({val1, ack1, id1} !== {1'b1, 4'b0001, 2'd0}) begin
         tests_failed++;
         $display("[TB] FAIL withdraw_c1: got %b expected %b", {val1, ack1, id1}, 7'b1000100);
      end
      dcb_in_req = 4'b1010;
      tick();
      tick();
      dcb_in_req = 4'b1000;
      for (int c = 4; c <= 9; c++) tick();
      tests_run++;
      if ({val1, ack1, id1, data1} !== {1'b1, 4'b1000, 2'd3, 32'h3333_3333}) begin
         tests_failed++;
         $display("[TB] FAIL withdraw_c9: got %h expected %h",
                  {val1, ack1, id1, data1}, {1'b1, 4'b1000, 2'd3, 32'h3333_3333});
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      dcb_rst      = 1'b1;
      dcb_en       = 1'b0;
      dcb_in_req   = 4'b0000;
      dcb_in_data  = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_pulse3();
      test_enable();
      test_reset_mid();
      test_withdraw();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
